// File: rtl/stack_cpu_sequencer.sv
// Program sequencer for a nibble-serial stack CPU: holds a 16-entry program,
// resets the CPU, streams opcode/operand nibbles with per-opcode exec timing, captures the result.
module stack_cpu_sequencer #(
  parameter int PROG_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       prog_we,
  input  logic [3:0] prog_addr,
  input  logic [7:0] prog_data,
  input  logic [4:0] prog_len,
  input  logic       start,
  input  logic [7:0] cpu_io_out,
  output logic       cpu_rst,
  output logic [3:0] cpu_inbits,
  output logic [1:0] cpu_output_mode,
  output logic       busy,
  output logic       done,
  output logic [7:0] result
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CPURST,
    S_FETCH,
    S_EXEC,
    S_CAPTURE
  } state_e;

  localparam logic [4:0] MAX_LEN = 5'(PROG_DEPTH);

  state_e      state_q, state_d;
  logic [4:0]  pc_q, pc_d;
  logic [4:0]  len_q, len_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  result_q, result_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic [3:0]  inbits_q, inbits_d;
  logic [7:0]  prog_mem_q [PROG_DEPTH];
  logic [3:0]  fetch_op;
  logic [7:0]  next_entry;

  function automatic logic [1:0] exec_cycles(input logic [3:0] op);
    case (op)
      4'h1, 4'h2, 4'h5, 4'h6, 4'h7, 4'h8: exec_cycles = 2'd2;
      4'h9, 4'hA, 4'hC, 4'hD:             exec_cycles = 2'd3;
      default:                            exec_cycles = 2'd1;
    endcase
  endfunction

  // Program memory has no reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (prog_we && state_q == S_IDLE) prog_mem_q[prog_addr] <= prog_data;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    result_d   = result_q;
    fetch_op   = prog_mem_q[pc_q[3:0]][7:4];
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
          pc_d    = '0;
          busy_d  = 1'b1;
          state_d = S_CPURST;
        end
      end
      S_CPURST: state_d = (len_q == '0) ? S_CAPTURE : S_FETCH;
      S_FETCH: begin
        cnt_d   = exec_cycles(fetch_op);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (cnt_q <= 2'd1) begin
          cnt_d   = '0;
          pc_d    = pc_q + 5'd1;
          state_d = (pc_d < len_q) ? S_FETCH : S_CAPTURE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_CAPTURE: begin
        result_d = cpu_io_out;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // CPU-facing outputs are registered from the next state so they align with it.
    next_entry = prog_mem_q[pc_d[3:0]];
    cpu_rst_d  = (state_d == S_CPURST);
    case (state_d)
      S_FETCH: inbits_d = next_entry[7:4];
      S_EXEC:  inbits_d = next_entry[3:0];
      default: inbits_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      cpu_rst_q <= 1'b1;
      inbits_q  <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      cpu_rst_q <= cpu_rst_d;
      inbits_q  <= inbits_d;
    end
  end

  assign cpu_rst         = cpu_rst_q;
  assign cpu_inbits      = inbits_q;
  assign cpu_output_mode = 2'b00;
  assign busy            = busy_q;
  assign done            = done_q;
  assign result          = result_q;

endmodule

// File: tb/tb_stack_cpu_sequencer.sv
// Directed bench for stack_cpu_sequencer; a CPU stand-in presents the reference
// result on cpu_io_out only during the capture cycle, so capture timing is checked too.
module tb_stack_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic [4:0] prog_len;
  logic       start;
  logic [7:0] cpu_io_out;
  logic       cpu_rst;
  logic [3:0] cpu_inbits;
  logic [1:0] cpu_output_mode;
  logic       busy;
  logic       done;
  logic [7:0] result;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  stack_cpu_sequencer #(.PROG_DEPTH(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .prog_we         (prog_we),
    .prog_addr       (prog_addr),
    .prog_data       (prog_data),
    .prog_len        (prog_len),
    .start           (start),
    .cpu_io_out      (cpu_io_out),
    .cpu_rst         (cpu_rst),
    .cpu_inbits      (cpu_inbits),
    .cpu_output_mode (cpu_output_mode),
    .busy            (busy),
    .done            (done),
    .result          (result)
  );

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_entry(input logic [3:0] addr, input logic [7:0] data);
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = addr;
    prog_data = data;
    @(negedge clk);
    prog_we   = 1'b0;
  endtask

  // k counts cycles after the start edge; done is expected at k == n_exp and
  // the capture cycle is k == n_exp-1. The trace holds cpu_inbits for k = 1..n_exp-1.
  task automatic run(input string tag, input logic [4:0] len, input logic [7:0] ref_res,
                     input int n_exp, input logic [159:0] exp_trace, input bit disturb,
                     input bit sim_wr, input logic [3:0] wr_addr, input logic [7:0] wr_data);
    logic [159:0] tr;
    logic [39:0]  rs;
    logic [39:0]  rs_exp;
    int           k;
    int           done_k;
    bit           busy_ok;
    @(negedge clk);
    check({tag, " idle busy"}, 160'(busy), 160'(0));
    prog_len   = len;
    start      = 1'b1;
    cpu_io_out = ~ref_res;
    if (sim_wr) begin
      prog_we   = 1'b1;
      prog_addr = wr_addr;
      prog_data = wr_data;
    end
    @(posedge clk);
    #1;
    start   = 1'b0;
    prog_we = 1'b0;
    k       = 1;
    tr      = '0;
    rs      = '0;
    busy_ok = 1'b1;
    done_k  = -1;
    while (k < 100) begin
      if (done) begin
        done_k = k;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      tr = {tr[155:0], cpu_inbits};
      rs = {rs[38:0], cpu_rst};
      cpu_io_out = (k == n_exp - 1) ? ref_res : ~ref_res;
      if (disturb && k == 4) begin
        start     = 1'b1;
        prog_we   = 1'b1;
        prog_addr = 4'd0;
        prog_data = 8'hFF;
        prog_len  = 5'd1;
      end
      if (disturb && k == 5) begin
        start    = 1'b0;
        prog_we  = 1'b0;
        prog_len = len;
      end
      @(posedge clk);
      #1;
      k++;
    end
    rs_exp = 40'd1 << (n_exp - 2);
    check({tag, " done cycle"}, 160'(done_k), 160'(n_exp));
    check({tag, " busy during run"}, 160'(busy_ok), 160'(1));
    check({tag, " inbits trace"}, tr, exp_trace);
    check({tag, " cpu_rst trace"}, 160'(rs), 160'(rs_exp));
    check({tag, " result"}, 160'(result), 160'(ref_res));
    check({tag, " busy at done"}, 160'(busy), 160'(0));
    @(posedge clk);
    #1;
    check({tag, " done width"}, 160'(done), 160'(0));
    check({tag, " result hold"}, 160'(result), 160'(ref_res));
  endtask

  task automatic load_prog1();
    write_entry(4'd0, 8'h13);
    write_entry(4'd1, 8'h15);
    write_entry(4'd2, 8'h80);
    write_entry(4'd3, 8'h30);
  endtask

  localparam logic [159:0] TRACE_P1 = 160'h0133155800300;

  initial begin
    bit saw_done;
    rst_n      = 1'b0;
    prog_we    = 1'b0;
    prog_addr  = '0;
    prog_data  = '0;
    prog_len   = '0;
    start      = 1'b0;
    cpu_io_out = '0;
    #12;
    check("reset busy", 160'(busy), 160'(0));
    check("reset done", 160'(done), 160'(0));
    check("reset result", 160'(result), 160'(0));
    check("reset cpu_rst", 160'(cpu_rst), 160'(1));
    check("reset inbits", 160'(cpu_inbits), 160'(0));
    check("reset mode", 160'(cpu_output_mode), 160'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post-reset cpu_rst", 160'(cpu_rst), 160'(0));

    load_prog1();
    run("p1", 5'd4, 8'h08, 14, TRACE_P1, 1'b0, 1'b0, 4'd0, 8'h00);

    write_entry(4'd0, 8'h17);
    write_entry(4'd1, 8'h16);
    write_entry(4'd2, 8'h90);
    write_entry(4'd3, 8'h40);
    write_entry(4'd4, 8'h20);
    write_entry(4'd5, 8'h30);
    run("p2", 5'd6, 8'h2A, 20, 160'h0177166900040200300, 1'b0, 1'b0, 4'd0, 8'h00);

    write_entry(4'd0, 8'h15);
    write_entry(4'd1, 8'h10);
    write_entry(4'd2, 8'hA0);
    write_entry(4'd3, 8'h62);
    write_entry(4'd4, 8'h30);
    run("p3", 5'd5, 8'h02, 18, 160'h0155100A000622300, 1'b0, 1'b0, 4'd0, 8'h00);

    run("len0", 5'd0, 8'h00, 3, 160'h00, 1'b0, 1'b0, 4'd0, 8'h00);

    // Entry 3 currently 0x62; the write issued alongside start must be seen by the run.
    write_entry(4'd0, 8'h13);
    write_entry(4'd1, 8'h15);
    write_entry(4'd2, 8'h80);
    run("wr+start", 5'd4, 8'h08, 14, TRACE_P1, 1'b0, 1'b1, 4'd3, 8'h30);

    for (int unsigned i = 0; i < 16; i++)
      write_entry(4'(i), (i % 2 == 0) ? 8'hE2 : 8'hB3);
    run("clamp", 5'd31, 8'h5A, 35, 160'h0E2B3E2B3E2B3E2B3E2B3E2B3E2B3E2B30, 1'b0, 1'b0, 4'd0, 8'h00);

    load_prog1();
    run("disturbed", 5'd4, 8'h08, 14, TRACE_P1, 1'b1, 1'b0, 4'd0, 8'h00);
    run("after disturb", 5'd4, 8'h08, 14, TRACE_P1, 1'b0, 1'b0, 4'd0, 8'h00);

    // Abort in the first EXEC cycle (k == 3).
    @(negedge clk);
    prog_len = 5'd4;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("abort pre inbits", 160'(cpu_inbits), 160'(3));
    #2;
    rst_n = 1'b0;
    #1;
    check("abort busy", 160'(busy), 160'(0));
    check("abort cpu_rst", 160'(cpu_rst), 160'(1));
    check("abort inbits", 160'(cpu_inbits), 160'(0));
    check("abort result", 160'(result), 160'(0));
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release cpu_rst held", 160'(cpu_rst), 160'(1));
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    check("abort no done", 160'(saw_done), 160'(0));
    check("release cpu_rst", 160'(cpu_rst), 160'(0));
    check("release busy", 160'(busy), 160'(0));

    run("rerun", 5'd4, 8'h08, 14, TRACE_P1, 1'b0, 1'b0, 4'd0, 8'h00);
    check("mode tied", 160'(cpu_output_mode), 160'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
